hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall-and-forward controller for the 5-stage P5 pipeline; the consumer of the CU's Tuse_Rs_D, Tuse_Rt_D and Tnew_D outputs.
- Keeps a shadow pipeline of in-flight writers (E, M, W slots: dest reg, Tnew, rs/rt addresses).
- Decrements Tnew each cycle and generates the stall signal plus the per-stage forwarding selects.
- Sits beside the datapath; drives PC/F-D enables, the D-E bubble, and the forwarding muxes in the D, E and M stages.

Parameters:
REG_AW, 5, register address width
T_W, 2, width of Tuse/Tnew fields

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
rs_D  in  5  rs address of instruction in D
rt_D  in  5  rt address of instruction in D
Tuse_Rs_D  in  2  from CU; cycles until rs needed (3 = never)
Tuse_Rt_D  in  2  from CU; cycles until rt needed (3 = never)
Tnew_D  in  2  from CU; Tnew the instruction will have on entering E
A3_D  in  5  destination reg of D instruction (0 = none)
RegWrite_D  in  1  D instruction writes GRF
stall  out  1  freeze PC and F/D; bubble into D/E
fwd_rs_D  out  2  D-stage rs mux select
fwd_rt_D  out  2  D-stage rt mux select
fwd_rs_E  out  2  E-stage rs mux select
fwd_rt_E  out  2  E-stage rt mux select
fwd_rt_M  out  1  M-stage rt (store data) from W

Behaviour:
- Slot contents: E, M, W each hold {A3, Tnew, rs, rt}. A3 = 0 means no writer. rs/rt are kept only in E and M.
- Every rising edge:
  - E <= stall ? bubble (all zero) : {RegWrite_D ? A3_D : 0, Tnew_D, rs_D, rt_D}.
  - M <= E with Tnew = sat_dec(Tnew_E).
  - W <= M with Tnew = 0.
  - sat_dec(x) = (x == 0) ? 0 : x - 1.
- reset: all slots are cleared to zero in the same edge. Combinational outputs follow, so after reset stall = 0, all fwd = 0.
- Stall (combinational):
  - stall_rs = (rs_D != 0) && ((rs_D == A3_E && Tuse_Rs_D < Tnew_E) || (rs_D == A3_M && Tuse_Rs_D < Tnew_M)). stall_rt is the same with rt.
  - stall = stall_rs | stall_rt.
  - A W-slot match never stalls.
- Forward encoding (2-bit): 0 = register file / pipeline register, 1 = from E, 2 = from M, 3 = from W.
- Only a producer with Tnew == 0 may be selected. Priority is youngest first.
  - D-stage: E (Tnew_E == 0), then M (Tnew_M == 0), then W.
  - E-stage: M, then W. Value 1 is never driven here.
  - M-stage rt: W only.
- Register 0 is never forwarded. A3 == 0 never matches, and a source address of 0 forces select 0.
- Simultaneous match in several slots: the youngest wins, even if the youngest is stalling. A stall then suppresses use of the D-stage value that cycle.
- Sustained stall: the bubble sets A3_E = 0, and M/W keep draining. The stall deasserts once the producer's Tnew reaches the consumer's Tuse (a load followed by a dependent beq stalls 2 cycles; a load followed by a dependent add stalls 1 cycle).
- Tuse = 3 (never used) can never stall, because Tnew ≤ 2.

Optional Feature:
- Macro HAZARD_MDU_EN.
- When defined, adds these inputs:
  - mdu_busy (1): MDU busy.
  - mdu_start_E (1): start pulse in E.
  - md_use_D (1): D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- stall additionally ORs md_use_D && (mdu_busy || mdu_start_E). The bubble rules are unchanged.
- When undefined, these ports do not exist and stall is exactly as above.

Decomposition:
- hazard_pkg holds:
  - FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3.
  - TUSE_NEVER = 3.
  - The slot struct/typedef {A3, Tnew, rs, rt}.
- Sub-module hazard_slot: one registered stage entry with sync clear, bubble input and saturating Tnew decrement. It is instantiated for E, M and W.

Test Plan:
1. Reset held 2 cycles with random D inputs. Expect stall = 0, all fwd = 0, slots zero; first edge after release loads E.
2. lw $8 (Tnew_D = 2), then beq $8 (Tuse_Rs = 0). Expect stall = 1 for 2 cycles, then fwd_rs_D = 3 (W) on the third cycle.
3. add $9 (Tnew_D = 1), then sub using $9 as rt (Tuse_Rt = 1). Expect stall = 0 and fwd_rt_E = 2 (M) in the consumer's E cycle.
4. jal (A3 = 31, Tnew_D = 0), then jr $31 (Tuse_Rs = 0). Expect stall = 0, fwd_rs_D = 1 (E).
5. ori $0 as producer, then an add reading $0. Expect no stall, all fwd = 0. Also: addu $5 then addu $5 back-to-back; the consumer takes the youngest (E/M), never W.
6. reset asserted mid-stall during the lw/beq sequence. Expect stall = 0 the next cycle and no stale forwarding from the cleared slots.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the P5 hazard controller.
//   FWD_*      : forwarding mux select encoding shared with the datapath
//   TUSE_NEVER : Tuse value meaning "operand never read"
//   slot_t     : one shadow-pipeline entry {a3, tnew, rs, rt}
//   sat_dec    : saturating Tnew decrement applied on the E->M move
package hazard_pkg;

  localparam int unsigned HZ_REG_AW = 5;
  localparam int unsigned HZ_T_W    = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [HZ_T_W-1:0] TUSE_NEVER = 2'd3;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] a3;    // destination register, 0 = no writer
    logic [HZ_T_W-1:0]    tnew;  // cycles until the result exists
    logic [HZ_REG_AW-1:0] rs;
    logic [HZ_REG_AW-1:0] rt;
  } slot_t;

  // How a slot derives its Tnew from the entry it captures.
  typedef enum logic [1:0] {TnewKeep, TnewDec, TnewClear} tnew_mode_e;

  function automatic logic [HZ_T_W-1:0] sat_dec(input logic [HZ_T_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One registered entry of the hazard shadow pipeline.
//   clk, reset : rising-edge clock, synchronous active-high clear
//   bubble     : capture an all-zero entry instead of slot_in
//   slot_in    : entry from the previous stage
//   slot_out   : registered entry
// TnewMode selects keep / saturating decrement / clear of Tnew on capture;
// KeepSrc = 0 drops rs/rt for stages nobody forwards into.
module hazard_slot
  import hazard_pkg::*;
#(
  parameter tnew_mode_e TnewMode = TnewKeep,
  parameter bit         KeepSrc  = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble,
  input  slot_t slot_in,
  output slot_t slot_out
);

  slot_t slot_d, slot_q;

  always_comb begin
    slot_d = slot_in;
    unique case (TnewMode)
      TnewDec:   slot_d.tnew = sat_dec(slot_in.tnew);
      TnewClear: slot_d.tnew = '0;
      default:   slot_d.tnew = slot_in.tnew;
    endcase
    if (!KeepSrc) begin
      slot_d.rs = '0;
      slot_d.rt = '0;
    end
    if (bubble) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_out = slot_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall-and-forward controller for the 5-stage P5 pipeline.
// Tracks in-flight writers in a shadow E/M/W pipeline and derives the stall
// and the D/E/M forwarding selects from the CU's Tuse/Tnew values.
//   clk, reset                   : clock, synchronous active-high reset
//   rs_D, rt_D                   : source registers of the D instruction
//   Tuse_Rs_D, Tuse_Rt_D         : cycles until each source is needed (3 = never)
//   Tnew_D, A3_D, RegWrite_D     : result timing and destination of the D instruction
//   stall                        : freeze PC and F/D, bubble into D/E
//   fwd_rs_D, fwd_rt_D           : D-stage selects (0 RF, 1 E, 2 M, 3 W)
//   fwd_rs_E, fwd_rt_E           : E-stage selects (0 RF, 2 M, 3 W)
//   fwd_rt_M                     : M-stage store data from W
// Optional macro HAZARD_MDU_EN adds mdu_busy, mdu_start_E and md_use_D and
// stalls MDU instructions while the multiply/divide unit is occupied.
// REG_AW and T_W must match the widths in hazard_pkg.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = HZ_REG_AW,
  parameter int unsigned T_W    = HZ_T_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [T_W-1:0]    Tuse_Rs_D,
  input  logic [T_W-1:0]    Tuse_Rt_D,
  input  logic [T_W-1:0]    Tnew_D,
  input  logic [REG_AW-1:0] A3_D,
  input  logic              RegWrite_D,
`ifdef HAZARD_MDU_EN
  input  logic              mdu_busy,
  input  logic              mdu_start_E,
  input  logic              md_use_D,
`endif
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              fwd_rt_M
);

  slot_t d_entry, e_q, m_q, w_q;
  logic  stall_rs, stall_rt, stall_gpr;

  // A source stalls when an unfinished producer in E or M writes it.
  // W always has Tnew = 0 and is never considered.
  function automatic logic src_stall(input logic [HZ_REG_AW-1:0] src,
                                     input logic [HZ_T_W-1:0]    tuse,
                                     input slot_t                e,
                                     input slot_t                m);
    logic hit_e, hit_m;
    hit_e = (src == e.a3) && (tuse < e.tnew);
    hit_m = (src == m.a3) && (tuse < m.tnew);
    return (src != '0) && (tuse != TUSE_NEVER) && (hit_e || hit_m);
  endfunction

  // Youngest matching producer wins; if it is not ready yet the select
  // falls back to RF rather than to an older, stale producer.
  function automatic logic [1:0] fwd_sel_d(input logic [HZ_REG_AW-1:0] src,
                                           input slot_t                e,
                                           input slot_t                m,
                                           input logic [HZ_REG_AW-1:0] w_a3);
    if (src == '0)   return FWD_RF;
    if (src == e.a3) return (e.tnew == '0) ? FWD_E : FWD_RF;
    if (src == m.a3) return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (src == w_a3) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [HZ_REG_AW-1:0] src,
                                           input slot_t                m,
                                           input logic [HZ_REG_AW-1:0] w_a3);
    if (src == '0)   return FWD_RF;
    if (src == m.a3) return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (src == w_a3) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    d_entry      = '0;
    d_entry.a3   = RegWrite_D ? A3_D : '0;
    d_entry.tnew = Tnew_D;
    d_entry.rs   = rs_D;
    d_entry.rt   = rt_D;
  end

  hazard_slot #(
    .TnewMode (TnewKeep),
    .KeepSrc  (1'b1)
  ) u_slot_e (
    .clk      (clk),
    .reset    (reset),
    .bubble   (stall),
    .slot_in  (d_entry),
    .slot_out (e_q)
  );

  hazard_slot #(
    .TnewMode (TnewDec),
    .KeepSrc  (1'b1)
  ) u_slot_m (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .slot_in  (e_q),
    .slot_out (m_q)
  );

  hazard_slot #(
    .TnewMode (TnewClear),
    .KeepSrc  (1'b0)
  ) u_slot_w (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .slot_in  (m_q),
    .slot_out (w_q)
  );

  always_comb begin
    stall_rs  = src_stall(rs_D, Tuse_Rs_D, e_q, m_q);
    stall_rt  = src_stall(rt_D, Tuse_Rt_D, e_q, m_q);
    stall_gpr = stall_rs | stall_rt;
  end

`ifdef HAZARD_MDU_EN
  assign stall = stall_gpr | (md_use_D & (mdu_busy | mdu_start_E));
`else
  assign stall = stall_gpr;
`endif

  always_comb begin
    fwd_rs_D = fwd_sel_d(rs_D, e_q, m_q, w_q.a3);
    fwd_rt_D = fwd_sel_d(rt_D, e_q, m_q, w_q.a3);
    fwd_rs_E = fwd_sel_e(e_q.rs, m_q, w_q.a3);
    fwd_rt_E = fwd_sel_e(e_q.rt, m_q, w_q.a3);
    fwd_rt_M = (m_q.rt != '0) && (m_q.rt == w_q.a3);
  end

  // W keeps only its destination; M's rs has no consumer downstream.
  logic unused_slots;
  assign unused_slots = ^{w_q.tnew, w_q.rs, w_q.rt, m_q.rs};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use stall, ALU forwarding,
// jal/jr, register-0 handling, back-to-back writers and reset mid-stall.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, A3_D;
  logic [1:0] Tuse_Rs_D, Tuse_Rt_D, Tnew_D;
  logic       RegWrite_D;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
`ifdef HAZARD_MDU_EN
  logic       mdu_busy    = 1'b0;
  logic       mdu_start_E = 1'b0;
  logic       md_use_D    = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .Tuse_Rs_D  (Tuse_Rs_D),
    .Tuse_Rt_D  (Tuse_Rt_D),
    .Tnew_D     (Tnew_D),
    .A3_D       (A3_D),
    .RegWrite_D (RegWrite_D),
`ifdef HAZARD_MDU_EN
    .mdu_busy   (mdu_busy),
    .mdu_start_E(mdu_start_E),
    .md_use_D   (md_use_D),
`endif
    .stall      (stall),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_rs_E   (fwd_rs_E),
    .fwd_rt_E   (fwd_rt_E),
    .fwd_rt_M   (fwd_rt_M)
  );

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                       input logic [1:0] tu_rt, input logic [1:0] tn, input logic [4:0] a3,
                       input logic rw);
    rs_D = rs; rt_D = rt; Tuse_Rs_D = tu_rs; Tuse_Rt_D = tu_rt;
    Tnew_D = tn; A3_D = a3; RegWrite_D = rw;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    set_d(5'd0, 5'd0, TUSE_NEVER, TUSE_NEVER, 2'd0, 5'd0, 1'b0);
  endtask

  task automatic flush;
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_d(5'($urandom_range(31)), 5'($urandom_range(31)), 2'($urandom_range(3)),
          2'($urandom_range(3)), 2'($urandom_range(3)), 5'($urandom_range(31)), 1'b1);
    repeat (2) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL rst_fwd_rs_D: got %0d want 0", fwd_rs_D); end
    checks++; if (fwd_rt_D !== 2'd0) begin errors++; $display("FAIL rst_fwd_rt_D: got %0d want 0", fwd_rt_D); end
    checks++; if (fwd_rs_E !== 2'd0) begin errors++; $display("FAIL rst_fwd_rs_E: got %0d want 0", fwd_rs_E); end
    checks++; if (fwd_rt_E !== 2'd0) begin errors++; $display("FAIL rst_fwd_rt_E: got %0d want 0", fwd_rt_E); end
    checks++; if (fwd_rt_M !== 1'b0) begin errors++; $display("FAIL rst_fwd_rt_M: got %0b want 0", fwd_rt_M); end
    // First edge after release must capture the D instruction into E.
    reset = 1'b0;
    set_d(5'd0, 5'd0, TUSE_NEVER, TUSE_NEVER, 2'd0, 5'd12, 1'b1);
    tick();
    set_d(5'd12, 5'd0, 2'd0, TUSE_NEVER, 2'd0, 5'd0, 1'b0);
    #1;
    checks++; if (fwd_rs_D !== 2'd1) begin errors++; $display("FAIL rst_first_load: fwd_rs_D got %0d want 1", fwd_rs_D); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_first_stall: got %0b want 0", stall); end
    flush();
  endtask

  task automatic test_load_use_beq;
    set_d(5'd29, 5'd8, 2'd1, TUSE_NEVER, 2'd2, 5'd8, 1'b1);  // lw $8, 0($29)
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_no_stall: got %0b want 0", stall); end
    tick();
    set_d(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);         // beq $8, $0
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall1: got %0b want 1", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL lw_beq_fwd1: got %0d want 0", fwd_rs_D); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall2: got %0b want 1", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL lw_beq_fwd2: got %0d want 0", fwd_rs_D); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_beq_stall3: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd3) begin errors++; $display("FAIL lw_beq_fwd3: got %0d want 3", fwd_rs_D); end
    checks++; if (fwd_rt_D !== 2'd0) begin errors++; $display("FAIL lw_beq_fwd_rt: got %0d want 0", fwd_rt_D); end
    flush();
  endtask

  task automatic test_alu_fwd;
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 5'd9, 1'b1);         // add $9, $1, $2
    tick();
    set_d(5'd3, 5'd9, 2'd1, 2'd1, 2'd1, 5'd10, 1'b1);        // sub $10, $3, $9
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", stall); end
    checks++; if (fwd_rt_D !== 2'd0) begin errors++; $display("FAIL alu_fwd_rt_D: got %0d want 0", fwd_rt_D); end
    tick();
    nop();
    #1;
    checks++; if (fwd_rt_E !== 2'd2) begin errors++; $display("FAIL alu_fwd_rt_E: got %0d want 2", fwd_rt_E); end
    checks++; if (fwd_rs_E !== 2'd0) begin errors++; $display("FAIL alu_fwd_rs_E: got %0d want 0", fwd_rs_E); end
    tick();
    // sub in M reads rt=$9 while add sits in W.
    checks++; if (fwd_rt_M !== 1'b1) begin errors++; $display("FAIL alu_fwd_rt_M: got %0b want 1", fwd_rt_M); end
    flush();
  endtask

  task automatic test_jal_jr;
    set_d(5'd0, 5'd0, TUSE_NEVER, TUSE_NEVER, 2'd0, 5'd31, 1'b1);  // jal
    tick();
    set_d(5'd31, 5'd0, 2'd0, TUSE_NEVER, 2'd0, 5'd0, 1'b0);        // jr $31
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_stall: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd1) begin errors++; $display("FAIL jr_fwd_rs_D: got %0d want 1", fwd_rs_D); end
    flush();
  endtask

  task automatic test_zero_reg;
    set_d(5'd4, 5'd0, 2'd1, TUSE_NEVER, 2'd2, 5'd0, 1'b1);   // lw $0, 0($4)
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 2'd1, 5'd11, 1'b1);        // reads $0 at Tuse 0
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs_D: got %0d want 0", fwd_rs_D); end
    checks++; if (fwd_rt_D !== 2'd0) begin errors++; $display("FAIL zero_fwd_rt_D: got %0d want 0", fwd_rt_D); end
    tick();
    nop();
    #1;
    checks++; if (fwd_rs_E !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs_E: got %0d want 0", fwd_rs_E); end
    checks++; if (fwd_rt_E !== 2'd0) begin errors++; $display("FAIL zero_fwd_rt_E: got %0d want 0", fwd_rt_E); end
    flush();
  endtask

  task automatic test_back_to_back;
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 5'd5, 1'b1);         // addu $5, $1, $2
    tick();
    set_d(5'd5, 5'd6, 2'd1, 2'd1, 2'd1, 5'd5, 1'b1);         // addu $5, $5, $6
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL b2b_fwd_rs_D1: got %0d want 0", fwd_rs_D); end
    tick();
    set_d(5'd5, 5'd0, 2'd1, 2'd1, 2'd1, 5'd7, 1'b1);         // addu $7, $5, $0
    #1;
    // E holds an unfinished $5 writer; the older ready copy in M must not win.
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL b2b_fwd_rs_D2: got %0d want 0", fwd_rs_D); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall2: got %0b want 0", stall); end
    checks++; if (fwd_rs_E !== 2'd2) begin errors++; $display("FAIL b2b_fwd_rs_E1: got %0d want 2", fwd_rs_E); end
    tick();
    set_d(5'd5, 5'd0, 2'd0, TUSE_NEVER, 2'd0, 5'd0, 1'b0);   // jr $5
    #1;
    // Both M and W write $5: M is younger.
    checks++; if (fwd_rs_E !== 2'd2) begin errors++; $display("FAIL b2b_fwd_rs_E2: got %0d want 2", fwd_rs_E); end
    checks++; if (fwd_rs_D !== 2'd2) begin errors++; $display("FAIL b2b_fwd_rs_D3: got %0d want 2", fwd_rs_D); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall3: got %0b want 0", stall); end
    flush();
  endtask

  task automatic test_reset_mid_stall;
    set_d(5'd29, 5'd8, 2'd1, TUSE_NEVER, 2'd2, 5'd8, 1'b1);  // lw $8
    tick();
    set_d(5'd8, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);         // beq $8, $0
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre_stall: got %0b want 1", stall); end
    reset = 1'b1;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall: got %0b want 0", stall); end
    checks++; if (fwd_rs_D !== 2'd0) begin errors++; $display("FAIL rms_fwd_rs_D: got %0d want 0", fwd_rs_D); end
    reset = 1'b0;
    tick();
    nop();
    #1;
    checks++; if (fwd_rs_E !== 2'd0) begin errors++; $display("FAIL rms_fwd_rs_E: got %0d want 0", fwd_rs_E); end
    checks++; if (fwd_rt_M !== 1'b0) begin errors++; $display("FAIL rms_fwd_rt_M: got %0b want 0", fwd_rt_M); end
    tick();
    checks++; if (fwd_rt_M !== 1'b0) begin errors++; $display("FAIL rms_fwd_rt_M2: got %0b want 0", fwd_rt_M); end
    flush();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    test_reset();
    test_load_use_beq();
    test_alu_fwd();
    test_jal_jr();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
